// File: rtl/ioblock_pkg.sv
//==============================================================================
// Module      : ioblock_pkg
// Description : Shared encodings and field offsets for the ioblock_bank pin
//               configuration nibble.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ioblock_pkg;

    localparam int CFG_BITS_PER_PIN = 4;

    localparam int CFG_TSMUX_LSB = 0;
    localparam int CFG_DORREG    = 2;
    localparam int CFG_OREG      = 3;

    typedef enum logic [1:0] {
        TS_OFF = 2'b00,
        TS_HI  = 2'b01,
        TS_LO  = 2'b10,
        TS_ON  = 2'b11
    } tsmux_e;

    function automatic logic pin_drive_en(input tsmux_e mux, input logic ts);
        logic en;
        en = 1'b0;
        case (mux)
            TS_OFF:  en = 1'b0;
            TS_HI:   en = ts;
            TS_LO:   en = ~ts;
            TS_ON:   en = 1'b1;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ioblock_cell.sv
//==============================================================================
// Module      : ioblock_cell
// Description : Datapath for one bidirectional pin: optional output/TS flops,
//               tristate driver and optional input flop(s).
//               Macro IOBANK_INSYNC_EN selects a two-flop input synchroniser.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ioblock_cell
    import ioblock_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CFG_BITS_PER_PIN-1:0] cfg,
    input  logic                        ts,
    input  logic                        dout,
    output logic                        din,
    inout  wire                         pad
);

    tsmux_e tsmux;
    logic   oreg;
    logic   dorreg;

    assign tsmux  = tsmux_e'(cfg[CFG_TSMUX_LSB +: 2]);
    assign oreg   = cfg[CFG_OREG];
    assign dorreg = cfg[CFG_DORREG];

    logic ts_q;
    logic out_q;

    // Output flops run every cycle regardless of OREG so switching modes
    // never exposes a stale value older than one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            ts_q  <= ts;
            out_q <= dout;
        end
    end

    logic ts_sel;
    logic d_sel;
    logic oe;

    assign ts_sel = oreg ? ts_q  : ts;
    assign d_sel  = oreg ? out_q : dout;
    assign oe     = pin_drive_en(tsmux, ts_sel);

    assign pad = oe ? d_sel : 1'bz;

    logic in_q;

`ifdef IOBANK_INSYNC_EN
    logic in_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_meta <= 1'b0;
            in_q    <= 1'b0;
        end else begin
            in_meta <= pad;
            in_q    <= in_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= pad;
        end
    end
`endif

    assign din = dorreg ? in_q : pad;

endmodule

`default_nettype wire

// File: rtl/ioblock_bank.sv
//==============================================================================
// Module      : ioblock_bank
// Description : Bank of WIDTH configurable bidirectional pins with a serial
//               configuration chain, atomic update and load-length checking.
//               Optional macro IOBANK_INSYNC_EN (two-flop input path).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ioblock_bank
    import ioblock_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CFG_BITS = CFG_BITS_PER_PIN * WIDTH
) (
    input  logic             IOCLK,
    input  logic             IORST_N,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] TS,
    input  logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] IN,
    input  logic             CFG_SE,
    input  logic             CFG_SI,
    output logic             CFG_SO,
    input  logic             CFG_UPD,
    output logic             CFG_ERR
);

    // Counter must hold CFG_BITS+1, the saturated "over-shifted" value.
    localparam int               CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    shift_cnt;

    always_ff @(posedge IOCLK or negedge IORST_N) begin
        if (!IORST_N) begin
            shadow    <= '0;
            active    <= '0;
            shift_cnt <= '0;
            CFG_ERR   <= 1'b0;
        end else if (CFG_UPD) begin
            if (shift_cnt == CNT_FULL) begin
                active  <= shadow;
                CFG_ERR <= 1'b0;
            end else begin
                CFG_ERR <= 1'b1;
            end
            shift_cnt <= '0;
        end else if (CFG_SE) begin
            shadow <= {shadow[CFG_BITS-2:0], CFG_SI};
            if (shift_cnt != CNT_SAT) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    assign CFG_SO = shadow[CFG_BITS-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ioblock_cell u_cell (
            .clk   (IOCLK),
            .rst_n (IORST_N),
            .cfg   (active[CFG_BITS_PER_PIN*i +: CFG_BITS_PER_PIN]),
            .ts    (TS[i]),
            .dout  (OUT[i]),
            .din   (IN[i]),
            .pad   (PIN[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_ioblock_bank.sv
//==============================================================================
// Module      : tb_ioblock_bank
// Description : Self-checking bench for ioblock_bank (WIDTH=8) with a
//               history-based reference model; honours IOBANK_INSYNC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ioblock_bank;

    localparam int W  = 8;
    localparam int CB = 4 * W;
`ifdef IOBANK_INSYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         IOCLK;
    logic         IORST_N;
    wire  [W-1:0] PIN;
    logic [W-1:0] TS;
    logic [W-1:0] OUT;
    logic [W-1:0] IN;
    logic         CFG_SE;
    logic         CFG_SI;
    logic         CFG_SO;
    logic         CFG_UPD;
    logic         CFG_ERR;

    logic [W-1:0] ext;
    logic [W-1:0] drv_en;

    ioblock_bank #(.WIDTH(W)) dut (
        .IOCLK   (IOCLK),
        .IORST_N (IORST_N),
        .PIN     (PIN),
        .TS      (TS),
        .OUT     (OUT),
        .IN      (IN),
        .CFG_SE  (CFG_SE),
        .CFG_SI  (CFG_SI),
        .CFG_SO  (CFG_SO),
        .CFG_UPD (CFG_UPD),
        .CFG_ERR (CFG_ERR)
    );

    for (genvar g = 0; g < W; g++) begin : g_ext
        assign PIN[g] = drv_en[g] ? ext[g] : 1'bz;
    end

    initial IOCLK = 1'b0;
    always #5 IOCLK = ~IOCLK;

    // Reference model: shifted-bit history, shift count, active config,
    // last-edge fabric values and history of pin values seen at edges.
    bit           hist[$];
    int           m_count;
    logic [CB-1:0] m_active;
    logic         m_err;
    logic [W-1:0] m_prev_ts;
    logic [W-1:0] m_prev_out;
    logic [W-1:0] pin_hist[$];

    logic [W-1:0] exp_pin;
    logic [W-1:0] exp_in;
    logic         exp_so;
    logic         exp_err;

    int  n_vec;
    int  n_err;
    bit  run;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [CB-1:0] shadow_val();
        logic [CB-1:0] s;
        int n;
        n = hist.size();
        for (int k = 0; k < CB; k++) s[k] = (k < n) ? hist[n-1-k] : 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        pin_hist.delete();
        m_count    = 0;
        m_active   = '0;
        m_err      = 1'b0;
        m_prev_ts  = '0;
        m_prev_out = '0;
    endtask

    task automatic refresh();
        logic [CB-1:0] sh;
        logic [3:0] nib;
        logic t, d, oe;
        int n;
        for (int i = 0; i < W; i++) begin
            nib = m_active[4*i +: 4];
            t   = nib[3] ? m_prev_ts[i]  : TS[i];
            d   = nib[3] ? m_prev_out[i] : OUT[i];
            oe  = (nib[1:0] == 2'd3) || (nib[1:0] == 2'd1 && t) || (nib[1:0] == 2'd2 && !t);
            drv_en[i]  = !oe;
            exp_pin[i] = oe ? d : ext[i];
            if (nib[2]) begin
                n = pin_hist.size();
                exp_in[i] = (n >= LAT) ? pin_hist[n-LAT][i] : 1'b0;
            end else begin
                exp_in[i] = exp_pin[i];
            end
        end
        sh      = shadow_val();
        exp_so  = sh[CB-1];
        exp_err = m_err;
    endtask

    task automatic apply(input logic [W-1:0] t, input logic [W-1:0] o, input logic [W-1:0] e,
                         input logic se, input logic si, input logic upd);
        TS      = t;
        OUT     = o;
        ext     = e;
        CFG_SE  = se;
        CFG_SI  = si;
        CFG_UPD = upd;
        refresh();
    endtask

    task automatic half();
        @(negedge IOCLK);
        #1;
    endtask

    task automatic edge_step();
        logic s_rst, s_se, s_si, s_upd;
        logic [W-1:0] s_ts, s_out, s_pin;
        s_rst = IORST_N; s_se = CFG_SE; s_si = CFG_SI; s_upd = CFG_UPD;
        s_ts = TS; s_out = OUT; s_pin = exp_pin;
        @(posedge IOCLK);
        #1;
        if (!s_rst) begin
            model_reset();
        end else begin
            if (s_upd) begin
                if (m_count == CB) begin
                    m_active = shadow_val();
                    m_err    = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_count = 0;
            end else if (s_se) begin
                hist.push_back(s_si);
                if (hist.size() > CB) void'(hist.pop_front());
                if (m_count < CB + 1) m_count++;
            end
            m_prev_ts  = s_ts;
            m_prev_out = s_out;
            pin_hist.push_back(s_pin);
            if (pin_hist.size() > 4) void'(pin_hist.pop_front());
        end
        refresh();
    endtask

    task automatic shift_n(input logic [63:0] w, input int n);
        for (int j = n - 1; j >= 0; j--) begin
            apply(W'(j * 29 + 3), W'(j * 53 + 7), W'(j * 91 + 1), 1'b1, w[j], 1'b0);
            half();
            edge_step();
        end
    endtask

    task automatic do_upd();
        apply('0, '0, '0, 1'b0, 1'b0, 1'b1);
        half();
        edge_step();
    endtask

    always @(negedge IOCLK) begin
        if (run) begin
            chk("pin", PIN, exp_pin);
            chk("in", IN, exp_in);
            chk("cfg_so", CFG_SO, exp_so);
            chk("cfg_err", CFG_ERR, exp_err);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    localparam logic [31:0] CFG_A = 32'h0000_0013;
    localparam logic [31:0] CFG_B = 32'h0000_4B23;
    localparam logic [31:0] CFG_C = 32'h8000_4B23;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        IORST_N = 1'b0;
        drv_en  = '1;
        model_reset();
        apply('0, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b0);
        run = 1'b1;

        // Reset state: all pins Z, IN follows external value
        half();
        chk("rst_pin", PIN, 8'hA5);
        chk("rst_in", IN, 8'hA5);
        chk("rst_so", CFG_SO, 1'b0);
        chk("rst_err", CFG_ERR, 1'b0);
        edge_step();
        apply('0, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b0);
        half();
        edge_step();
        IORST_N = 1'b1;

        // Config A: pin0 always drive, pin1 drive when TS=1
        shift_n({32'h0, CFG_A}, 32);
        do_upd();
        apply(8'h02, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("a_err", CFG_ERR, 1'b0);
        chk("a_ts1", PIN, 8'h03);
        edge_step();
        apply(8'h00, 8'hFD, 8'h02, 1'b0, 1'b0, 1'b0);
        half();
        chk("a_ts0", PIN, 8'h03);
        edge_step();

        // Short load rejected, config A retained
        shift_n({32'h0, CFG_B}, 31);
        do_upd();
        apply(8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("short_err", CFG_ERR, 1'b1);
        chk("short_keep", PIN, 8'h03);
        edge_step();

        // Config B: pin1 drive when TS=0, pin2 registered, pin3 registered input
        shift_n({32'h0, CFG_B}, 32);
        do_upd();
        apply(8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("b_err", CFG_ERR, 1'b0);
        chk("b_oreg_old", PIN, 8'h03);
        edge_step();
        apply(8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("b_oreg_new", PIN, 8'h07);
        edge_step();

        // Input register latency on pin3
        apply(8'h00, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0);
        half();
        chk("dor_0", IN, 8'h07);
        edge_step();
        apply(8'h00, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0);
        half();
        chk("dor_1", IN, (LAT == 1) ? 8'h0F : 8'h07);
        edge_step();
        apply(8'h00, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0);
        half();
        chk("dor_2", IN, 8'h0F);
        edge_step();

        // Shift and update together: update wins, chain holds
        shift_n({32'h0, CFG_C}, 32);
        apply(8'h00, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1);
        half();
        chk("seupd_so_pre", CFG_SO, 1'b1);
        edge_step();
        apply(8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("seupd_so", CFG_SO, 1'b1);
        chk("seupd_err", CFG_ERR, 1'b0);
        edge_step();

        // Over-shift rejected
        shift_n({32'h0, CFG_A}, 33);
        do_upd();
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("over_err", CFG_ERR, 1'b1);
        edge_step();

        // Reset mid-shift discards partial load
        shift_n(64'hFFFF_FFFF_FFFF_FFFF, 10);
        IORST_N = 1'b0;
        #1;
        model_reset();
        apply(8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
        half();
        chk("mid_rst_pin", PIN, 8'h5A);
        chk("mid_rst_err", CFG_ERR, 1'b0);
        edge_step();
        IORST_N = 1'b1;
        shift_n({32'h0, CFG_A}, 32);
        do_upd();
        apply(8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("post_rst_err", CFG_ERR, 1'b0);
        chk("post_rst_pin", PIN, 8'h03);
        edge_step();

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
